// File: rtl/e_mdu_pkg.sv
// Shared E-stage MDU definitions: op encodings, default latencies and a sizing helper.
package e_mdu_pkg;

    typedef enum logic [3:0] {
        MduMult  = 4'd0,
        MduMultu = 4'd1,
        MduDiv   = 4'd2,
        MduDivu  = 4'd3,
        MduMthi  = 4'd4,
        MduMtlo  = 4'd5,
        MduMfhi  = 4'd6,
        MduMflo  = 4'd7,
        MduNone  = 4'd8
    } mdu_op_e;

    localparam int unsigned DefaultMultLat = 5;
    localparam int unsigned DefaultDivLat  = 10;

    function automatic int unsigned max_lat(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// Combinational multiply/divide datapath for e_mdu.
// Divider is built only when MDU_DIV_EN is defined; otherwise quotient/remainder read as zero.
module mdu_arith #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder
);

    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;

    // Low 2*WIDTH bits of the product of the extended operands is the exact signed/unsigned result.
    assign a_ext   = {{WIDTH{is_signed & a[WIDTH-1]}}, a};
    assign b_ext   = {{WIDTH{is_signed & b[WIDTH-1]}}, b};
    assign product = a_ext * b_ext;

`ifdef MDU_DIV_EN
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;

    assign a_neg   = is_signed & a[WIDTH-1];
    assign b_neg   = is_signed & b[WIDTH-1];
    assign a_mag   = a_neg ? (~a + 1'b1) : a;
    assign b_mag   = b_neg ? (~b + 1'b1) : b;
    // Zero divisor is never committed by the caller; keep the operator well defined.
    assign divisor = (b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    assign q_mag   = a_mag / divisor;
    assign r_mag   = a_mag % divisor;

    assign quotient  = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
    assign remainder = a_neg ? (~r_mag + 1'b1) : r_mag;
`else
    assign quotient  = '0;
    assign remainder = '0;
`endif

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: HI/LO registers, busy down-counter and op control.
// Define MDU_DIV_EN to build the divider; without it DIV/DIVU are accepted as no-ops.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MULT_LAT = DefaultMultLat,
    parameter int unsigned DIV_LAT  = DefaultDivLat
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       MDUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] result
);

`ifdef MDU_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    localparam int unsigned MaxLat = max_lat(MULT_LAT, DivEn ? DIV_LAT : 0);
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   pend_hi_q, pend_hi_d;
    logic [WIDTH-1:0]   pend_lo_q, pend_lo_d;
    logic               pend_wr_q, pend_wr_d;
    logic [CntW-1:0]    cnt_q, cnt_d;

    logic               is_signed;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;

    assign is_signed = (MDUOp == MduMult) || (MDUOp == MduDiv);
    assign busy      = (cnt_q != '0);

    mdu_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .a         (A),
        .b         (B),
        .is_signed (is_signed),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        cnt_d     = cnt_q;

        if (busy) begin
            cnt_d = cnt_q - 1'b1;
            // Commit on the edge that ends the last busy cycle.
            if ((cnt_q == CntW'(1)) && pend_wr_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else if (start) begin
            case (MDUOp)
                MduMult, MduMultu: begin
                    cnt_d     = CntW'(MULT_LAT);
                    pend_hi_d = product[2*WIDTH-1:WIDTH];
                    pend_lo_d = product[WIDTH-1:0];
                    pend_wr_d = 1'b1;
                end
`ifdef MDU_DIV_EN
                MduDiv, MduDivu: begin
                    cnt_d     = CntW'(DIV_LAT);
                    pend_hi_d = remainder;
                    pend_lo_d = quotient;
                    pend_wr_d = (B != '0);
                end
`endif
                MduMthi: hi_d = A;
                MduMtlo: lo_d = A;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        result = '0;
        case (MDUOp)
            MduMfhi: result = hi_q;
            MduMflo: result = lo_q;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: directed scenarios plus random ops against a behavioural model.
module tb_e_mdu;
    import e_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  MDUOp = MduNone;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy;
    logic [31:0] result;

    always #5 clk = ~clk;

    e_mdu dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .MDUOp   (MDUOp),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .result  (result)
    );

    typedef struct {
        bit          busy;
        logic [31:0] result;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference model state: architectural HI/LO plus the in-flight result and time left.
    int          m_rem = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] m_phi = '0;
    logic [31:0] m_plo = '0;
    bit          m_pwr = 1'b0;

    function automatic void model_edge(input bit rst_n, input bit st, input logic [3:0] op,
                                       input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        if (!rst_n) begin
            m_rem = 0; m_hi = '0; m_lo = '0; m_pwr = 1'b0;
        end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0 && m_pwr) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (st) begin
            case (op)
                MduMult: begin
                    sp = longint'($signed(a)) * longint'($signed(b));
                    m_phi = sp[63:32]; m_plo = sp[31:0]; m_pwr = 1'b1; m_rem = DefaultMultLat;
                end
                MduMultu: begin
                    up = {32'b0, a} * {32'b0, b};
                    m_phi = up[63:32]; m_plo = up[31:0]; m_pwr = 1'b1; m_rem = DefaultMultLat;
                end
`ifdef MDU_DIV_EN
                MduDiv: begin
                    m_rem = DefaultDivLat;
                    m_pwr = (b != 0);
                    if (b != 0) begin
                        sp = longint'($signed(a)) / longint'($signed(b));
                        m_plo = sp[31:0];
                        sp = longint'($signed(a)) % longint'($signed(b));
                        m_phi = sp[31:0];
                    end
                end
                MduDivu: begin
                    m_rem = DefaultDivLat;
                    m_pwr = (b != 0);
                    if (b != 0) begin
                        m_plo = a / b;
                        m_phi = a % b;
                    end
                end
`endif
                MduMthi: m_hi = a;
                MduMtlo: m_lo = a;
                default: ;
            endcase
        end
    endfunction

    // Drive one cycle; the expectation for that cycle comes from the model before the edge.
    task automatic step(input bit rst_n, input bit st, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input string tag);
        exp_t e;
        reset_n = rst_n; start = st; MDUOp = op; A = a; B = b;
        e.busy   = (m_rem != 0);
        e.result = (op == MduMfhi) ? m_hi : (op == MduMflo) ? m_lo : 32'h0;
        e.tag    = tag;
        exp_q.push_back(e);
        @(posedge clk);
        model_edge(rst_n, st, op, a, b);
        #1;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, MduNone, $urandom, $urandom, tag);
    endtask

    task automatic read_both(input string tag);
        step(1'b1, 1'b0, MduMfhi, '0, '0, tag);
        step(1'b1, 1'b0, MduMflo, '0, '0, tag);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (busy !== e.busy) begin
                n_fail++;
                $display("FAIL busy[%s] got %0b want %0b at %0t", e.tag, busy, e.busy, $time);
            end
            n_checks++;
            if (result !== e.result) begin
                n_fail++;
                $display("FAIL result[%s] got %08h want %08h at %0t", e.tag, result, e.result,
                         $time);
            end
        end
    end

    initial begin
        logic [3:0] op;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset clears a previously written HI
        step(1'b1, 1'b1, MduMthi, 32'h1234, '0, "mthi");
        step(1'b1, 1'b0, MduMfhi, '0, '0, "mfhi_pre_rst");
        step(1'b0, 1'b0, MduNone, '0, '0, "rst0");
        step(1'b0, 1'b1, MduMtlo, 32'h55, '0, "rst1_with_start");
        read_both("post_rst");

        // Signed and unsigned multiply
        step(1'b1, 1'b1, MduMult, 32'hFFFF_FFFF, 32'd2, "mult");
        idle(5, "mult_busy");
        read_both("mult_res");
        step(1'b1, 1'b1, MduMultu, 32'hFFFF_FFFF, 32'd2, "multu");
        idle(5, "multu_busy");
        read_both("multu_res");

        // Signed and unsigned divide
        step(1'b1, 1'b1, MduDiv, 32'hFFFF_FFF9, 32'd2, "div");
        idle(10, "div_busy");
        read_both("div_res");
        step(1'b1, 1'b1, MduDivu, 32'd7, 32'd2, "divu");
        idle(10, "divu_busy");
        read_both("divu_res");

        // Divide by zero keeps HI/LO
        step(1'b1, 1'b1, MduMthi, 32'hAA, '0, "pre_hi");
        step(1'b1, 1'b1, MduMtlo, 32'hBB, '0, "pre_lo");
        step(1'b1, 1'b1, MduDiv, 32'd99, 32'd0, "div0");
        idle(10, "div0_busy");
        read_both("div0_res");

        // Most-negative / -1 wraps
        step(1'b1, 1'b1, MduDiv, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        idle(10, "div_ovf_busy");
        read_both("div_ovf_res");

        // Start while busy is ignored; operands changing mid-flight have no effect
        step(1'b1, 1'b1, MduDivu, 32'd100, 32'd7, "divu2");
        step(1'b1, 1'b1, MduMultu, 32'd5, 32'd5, "ignored_multu");
        step(1'b1, 1'b1, MduMthi, 32'hDEAD, 32'd1, "ignored_mthi");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, MduMflo, $urandom, $urandom, "mflo_busy");
        read_both("divu2_res");

        // Reset in busy cycle 3 of a multiply aborts it
        step(1'b1, 1'b1, MduMult, 32'd3, 32'd4, "mult_abort");
        idle(2, "abort_busy");
        step(1'b0, 1'b0, MduNone, '0, '0, "abort_rst");
        read_both("abort_res");
        idle(6, "abort_idle");
        read_both("abort_late");

        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 10));
            step(($urandom_range(0, 60) != 0), ($urandom_range(0, 3) != 0), op, pick(), pick(),
                 "rand");
        end
        idle(12, "drain");
        read_both("final");

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
